encoder_layer_1_attention_self_key_weight_replay: RTL and testbench

ENCODER_LAYER_1_ATTENTION_SELF_KEY_WEIGHT_REPLAY -- requirements
Module: encoder_layer_1_attention_self_key_weight_replay

---
 rtl/encoder_layer_1_attention_self_key_weight_replay.sv | 128 ++++++++++++
 tb/tb_encoder_layer_1_attention_self_key_weight_replay.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_layer_1_attention_self_key_weight_replay.sv
// rtl/encoder_layer_1_attention_self_key_weight_replay.sv - key weight tensor fill-and-replay buffer
//
// Purpose: forwards one weight tensor (DEPTH beats) straight through while
// capturing it, then replays the captured tensor REPEAT-1 more times so the
// upstream weight source only has to deliver each tensor once.
//
// Ports:
//   clk            - single clock, rising edge
//   rst            - synchronous active-low reset
//   data_in        - weight beat from the upstream source (P elements)
//   data_in_valid  - data_in holds a valid beat
//   data_in_ready  - beat on data_in is accepted
//   data_out       - weight beat to the downstream consumer (P elements)
//   data_out_valid - data_out holds a valid beat
//   data_out_ready - consumer accepts the beat on data_out
//   data_out_last  - final beat of every pass
module encoder_layer_1_attention_self_key_weight_replay #(
  parameter int KEY_WEIGHT_PRECISION_0 = 16,
  parameter int KEY_WEIGHT_PARALLELISM = 1,
  parameter int DEPTH                  = 32,
  parameter int REPEAT                 = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [KEY_WEIGHT_PARALLELISM*KEY_WEIGHT_PRECISION_0-1:0] data_in,
  input  logic                                                 data_in_valid,
  output logic                                                 data_in_ready,
  output logic [KEY_WEIGHT_PARALLELISM*KEY_WEIGHT_PRECISION_0-1:0] data_out,
  output logic                                                 data_out_valid,
  input  logic                                                 data_out_ready,
  output logic                                                 data_out_last
);

  localparam int BEAT_W = KEY_WEIGHT_PARALLELISM * KEY_WEIGHT_PRECISION_0;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  // Buffer is rounded up to a power of two so ptr indexes it at full width;
  // entries at or beyond DEPTH are never written or read.
  localparam int BUF_N  = 1 << PTR_W;

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(REPEAT - 1);

  typedef enum logic {
    FILL,
    REPLAY
  } state_t;

  state_t            state, state_next;
  logic [PTR_W-1:0]  ptr, ptr_next;
  logic [PASS_W-1:0] pass, pass_next;
  logic [BEAT_W-1:0] buffer [BUF_N];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL;
      ptr   <= '0;
      pass  <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      pass  <= pass_next;
    end
  end

  // No reset on the storage: data_in_ready is held low in reset and in
  // REPLAY, so this only captures genuine fill transfers.
  always_ff @(posedge clk) begin
    if (data_in_valid && data_in_ready) begin
      buffer[ptr] <= data_in;
    end
  end

  // Next-state terms use the raw inputs rather than the outputs computed
  // here, so this block has no combinational feedback on itself.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    pass_next      = pass;
    data_out       = '0;
    data_out_valid = 1'b0;
    data_in_ready  = 1'b0;

    if (rst) begin
      case (state)
        FILL: begin
          data_out       = data_in;
          data_out_valid = data_in_valid;
          data_in_ready  = data_out_ready;
          if (data_in_valid && data_out_ready) begin
            if (ptr == PTR_LAST) begin
              ptr_next = '0;
              if (REPEAT > 1) begin
                state_next = REPLAY;
                pass_next  = PASS_W'(1);
              end
            end else begin
              ptr_next = ptr + 1'b1;
            end
          end
        end
        REPLAY: begin
          data_out       = buffer[ptr];
          data_out_valid = 1'b1;
          if (data_out_ready) begin
            if (ptr == PTR_LAST) begin
              ptr_next = '0;
              if (pass == PASS_LAST) begin
                state_next = FILL;
                pass_next  = '0;
              end else begin
                pass_next = pass + 1'b1;
              end
            end else begin
              ptr_next = ptr + 1'b1;
            end
          end
        end
        default: begin
          state_next = FILL;
        end
      endcase
    end

    data_out_last = data_out_valid && (ptr == PTR_LAST);
  end

endmodule

// File: tb/tb_encoder_layer_1_attention_self_key_weight_replay.sv
// tb/tb_encoder_layer_1_attention_self_key_weight_replay.sv - directed bench for the key weight replay buffer
module tb_encoder_layer_1_attention_self_key_weight_replay;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [W-1:0] a_din, a_dout;
  logic         a_vin, a_rin, a_vout, a_rout, a_last;
  logic [W-1:0] b_din, b_dout;
  logic         b_vin, b_rin, b_vout, b_rout, b_last;
  logic [W-1:0] c_din, c_dout;
  logic         c_vin, c_rin, c_vout, c_rout, c_last;

  encoder_layer_1_attention_self_key_weight_replay #(
    .KEY_WEIGHT_PRECISION_0(W), .KEY_WEIGHT_PARALLELISM(1), .DEPTH(4), .REPEAT(3)
  ) dut_a (
    .clk(clk), .rst(rst),
    .data_in(a_din), .data_in_valid(a_vin), .data_in_ready(a_rin),
    .data_out(a_dout), .data_out_valid(a_vout), .data_out_ready(a_rout),
    .data_out_last(a_last)
  );

  encoder_layer_1_attention_self_key_weight_replay #(
    .KEY_WEIGHT_PRECISION_0(W), .KEY_WEIGHT_PARALLELISM(1), .DEPTH(4), .REPEAT(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .data_in(b_din), .data_in_valid(b_vin), .data_in_ready(b_rin),
    .data_out(b_dout), .data_out_valid(b_vout), .data_out_ready(b_rout),
    .data_out_last(b_last)
  );

  encoder_layer_1_attention_self_key_weight_replay #(
    .KEY_WEIGHT_PRECISION_0(W), .KEY_WEIGHT_PARALLELISM(1), .DEPTH(1), .REPEAT(2)
  ) dut_c (
    .clk(clk), .rst(rst),
    .data_in(c_din), .data_in_valid(c_vin), .data_in_ready(c_rin),
    .data_out(c_dout), .data_out_valid(c_vout), .data_out_ready(c_rout),
    .data_out_last(c_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [W-1:0] d, input logic r);
    a_vin = v; a_din = d; a_rout = r;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [W-1:0] d, input logic r);
    b_vin = v; b_din = d; b_rout = r;
    #1;
  endtask

  task automatic drive_c(input logic v, input logic [W-1:0] d, input logic r);
    c_vin = v; c_din = d; c_rout = r;
    #1;
  endtask

  task automatic check_a(input string tag, input logic v, input logic [W-1:0] d,
                         input logic r, input logic l);
    check({tag, ".valid"}, 32'(a_vout), 32'(v));
    if (v) check({tag, ".data"}, 32'(a_dout), 32'(d));
    check({tag, ".ready"}, 32'(a_rin), 32'(r));
    check({tag, ".last"}, 32'(a_last), 32'(l));
  endtask

  task automatic check_b(input string tag, input logic v, input logic [W-1:0] d,
                         input logic r, input logic l);
    check({tag, ".valid"}, 32'(b_vout), 32'(v));
    if (v) check({tag, ".data"}, 32'(b_dout), 32'(d));
    check({tag, ".ready"}, 32'(b_rin), 32'(r));
    check({tag, ".last"}, 32'(b_last), 32'(l));
  endtask

  task automatic check_c(input string tag, input logic v, input logic [W-1:0] d,
                         input logic r, input logic l);
    check({tag, ".valid"}, 32'(c_vout), 32'(v));
    if (v) check({tag, ".data"}, 32'(c_dout), 32'(d));
    check({tag, ".ready"}, 32'(c_rin), 32'(r));
    check({tag, ".last"}, 32'(c_last), 32'(l));
  endtask

  // Fill dut_a with four beats at full rate, checking the pass-through.
  task automatic fill_a(input string tag, input logic [W-1:0] t0, input logic [W-1:0] t1,
                        input logic [W-1:0] t2, input logic [W-1:0] t3);
    logic [W-1:0] t [4];
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, t[i], 1'b1);
      check_a(tag, 1'b1, t[i], 1'b1, i == 3);
      next_cycle();
    end
  endtask

  // Expect n replay beats from dut_a at full rate, cycling through t0..t3.
  task automatic replay_a(input string tag, input int n, input logic [W-1:0] t0,
                          input logic [W-1:0] t1, input logic [W-1:0] t2,
                          input logic [W-1:0] t3);
    logic [W-1:0] t [4];
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    for (int k = 0; k < n; k++) begin
      drive_a(1'b0, 8'h00, 1'b1);
      check_a(tag, 1'b1, t[k % 4], 1'b0, (k % 4) == 3);
      next_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic v;
    logic r;
    logic [W-1:0] d;
    logic [W-1:0] g [4];

    rst = 1'b0;
    drive_a(1'b1, 8'h5A, 1'b1);
    drive_b(1'b1, 8'h5B, 1'b1);
    drive_c(1'b1, 8'h5C, 1'b1);
    next_cycle();
    next_cycle();

    // Reset forces all handshake outputs and data low.
    check_a("reset_a", 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_a.data", 32'(a_dout), 32'h0);
    check_b("reset_b", 1'b0, 8'h00, 1'b0, 1'b0);
    check_c("reset_c", 1'b0, 8'h00, 1'b0, 1'b0);

    drive_a(1'b0, 8'h00, 1'b1);
    drive_b(1'b0, 8'h00, 1'b1);
    drive_c(1'b0, 8'h00, 1'b1);
    rst = 1'b1;
    next_cycle();

    // Basic fill then two replay passes, 12 consecutive output beats.
    fill_a("fill_basic", 8'h11, 8'h22, 8'h33, 8'h44);
    replay_a("replay_basic", 8, 8'h11, 8'h22, 8'h33, 8'h44);
    drive_a(1'b0, 8'h00, 1'b1);
    check_a("idle_basic", 1'b0, 8'h00, 1'b1, 1'b0);

    // Replay under consumer backpressure.
    fill_a("fill_bp", 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    g[0] = 8'hA1; g[1] = 8'hA2; g[2] = 8'hA3; g[3] = 8'hA4;
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      r = (c % 2) == 0;
      drive_a(1'b0, 8'h00, r);
      check_a("replay_bp", 1'b1, g[idx % 4], 1'b0, (idx % 4) == 3);
      if (r) idx++;
      next_cycle();
    end
    check("replay_bp.count", 32'(idx), 32'd8);
    drive_a(1'b0, 8'h00, 1'b1);
    check_a("idle_bp", 1'b0, 8'h00, 1'b1, 1'b0);

    // Gapped input valid during fill; junk on idle cycles must not be stored.
    g[0] = 8'h31; g[1] = 8'h32; g[2] = 8'h33; g[3] = 8'h34;
    for (int j = 0; j < 10; j++) begin
      v = (j % 3) == 0;
      d = v ? g[j / 3] : 8'hEE;
      drive_a(v, d, 1'b1);
      check_a("fill_gap", v, d, 1'b1, v && (j == 9));
      next_cycle();
    end
    replay_a("replay_gap", 8, 8'h31, 8'h32, 8'h33, 8'h34);

    // Reset during pass 2 at ptr 2, then a fresh tensor starting with 0xAA.
    fill_a("fill_rst", 8'h41, 8'h42, 8'h43, 8'h44);
    replay_a("replay_rst", 6, 8'h41, 8'h42, 8'h43, 8'h44);
    rst = 1'b0;
    drive_a(1'b1, 8'hAA, 1'b1);
    check_a("in_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    check("in_rst.data", 32'(a_dout), 32'h0);
    next_cycle();
    rst = 1'b1;
    drive_a(1'b1, 8'hAA, 1'b0);
    check_a("post_rst_stall", 1'b1, 8'hAA, 1'b0, 1'b0);
    next_cycle();
    fill_a("fill_new", 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    replay_a("replay_new", 8, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    drive_a(1'b0, 8'h00, 1'b1);
    check_a("idle_new", 1'b0, 8'h00, 1'b1, 1'b0);

    // REPEAT=1: pure pass-through across two tensors.
    for (int i = 0; i < 8; i++) begin
      drive_b(1'b1, 8'h60 + 8'(i), 1'b1);
      check_b("pass_r1", 1'b1, 8'h60 + 8'(i), 1'b1, (i % 4) == 3);
      next_cycle();
    end
    drive_b(1'b0, 8'h00, 1'b1);
    check_b("idle_r1", 1'b0, 8'h00, 1'b1, 1'b0);

    // DEPTH=1, REPEAT=2: same beat twice back to back, last on both.
    drive_c(1'b1, 8'h55, 1'b1);
    check_c("d1_fill", 1'b1, 8'h55, 1'b1, 1'b1);
    next_cycle();
    drive_c(1'b0, 8'h00, 1'b1);
    check_c("d1_replay", 1'b1, 8'h55, 1'b0, 1'b1);
    next_cycle();
    drive_c(1'b0, 8'h00, 1'b1);
    check_c("d1_idle", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
